mmu_array_param: RTL

Parametrised weight-stationary systolic matrix-multiply unit. Generalises the fixed 4x4 MMU to N x N with configurable operand and accumulator widths. Adds internal input skew and output deskew, valid/ready handshakes, a weight-load FSM and asynchronous reset. It is the compute core between the data/weight staging buffers and the accumulator bank.

---
 rtl/mmu_array_param.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mmu_array_param.sv
// mmu_array_param: parametrised N x N weight-stationary systolic matrix-multiply unit
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   wt_valid/wt_ready  weight row handshake; wt_row carries row r, column j at [j*DW +: DW]
//   data_valid/ready   input vector handshake; data_vec element i at [i*DW +: DW]
//   out_valid          one-cycle pulse per result, 2*N cycles after the accepting edge
//   acc_out            result vector, element j at [j*AW +: AW], held until next out_valid
//   weights_loaded     full weight matrix resident
//   busy               weight load in progress or vectors in flight
// Build option: define MMU_SIGNED_EN for two's-complement signed operands and results.
module mmu_array_param #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wt_valid,
    output logic            wt_ready,
    input  logic [N*DW-1:0] wt_row,
    input  logic            data_valid,
    output logic            data_ready,
    input  logic [N*DW-1:0] data_vec,
    output logic            out_valid,
    output logic [N*AW-1:0] acc_out,
    output logic            weights_loaded,
    output logic            busy
);
    localparam int RW = $clog2(N);
    localparam int CW = $clog2(2 * N + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   row, row_nxt, wr;
    logic [CW-1:0]   cnt;
    logic [2*N-1:0]  vp;
    logic            wt_acc, d_acc, last;
    logic [DW-1:0]   w [N][N];
    logic [DW-1:0]   in_reg [N];
    logic [DW-1:0]   s_row [N];
    logic [DW-1:0]   dr [N][N-1];
    logic [DW-1:0]   din [N][N];
    logic [AW-1:0]   ps [N][N];
    logic [AW-1:0]   pin [N][N];
    logic [AW-1:0]   col [N];

    function automatic logic [AW-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MMU_SIGNED_EN
        return AW'($signed(a)) * AW'($signed(b));
`else
        return AW'(a) * AW'(b);
`endif
    endfunction

    // A data accept in RUN with an empty pipeline wins over a weight beat.
    always_comb begin
        wt_ready   = state != RUN || (cnt == '0 && !data_valid);
        data_ready = state == RUN;
        busy       = state == LOAD || cnt != '0;
        wt_acc     = wt_valid && wt_ready;
        d_acc      = data_valid && data_ready;
        last       = row == RW'(N - 1);
        wr         = state == LOAD ? row : '0;
        state_nxt  = state;
        row_nxt    = row;
        if (wt_acc) begin
            state_nxt = state != LOAD ? LOAD : (last ? RUN : LOAD);
            row_nxt   = state != LOAD ? RW'(1) : (last ? '0 : row + RW'(1));
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            row   <= '0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt            <= '0;
            vp             <= '0;
            out_valid      <= 1'b0;
            weights_loaded <= 1'b0;
            acc_out        <= '0;
        end else begin
            cnt       <= d_acc && !out_valid ? cnt + CW'(1) : (!d_acc && out_valid ? cnt - CW'(1) : cnt);
            vp        <= {vp[2*N-2:0], d_acc};
            out_valid <= vp[2*N-1];
            if (wt_acc)
                weights_loaded <= state == LOAD && last;
            if (vp[2*N-1])
                for (int j = 0; j < N; j++)
                    acc_out[j*AW +: AW] <= col[j];
        end

    // PE inputs: data enters row i from the skew stage and moves right;
    // partial sums start at zero on row 0 and move down.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            din[i][0] = s_row[i];
            for (int j = 1; j < N; j++)
                din[i][j] = dr[i][j-1];
        end
        for (int j = 0; j < N; j++) begin
            pin[0][j] = '0;
            for (int i = 1; i < N; i++)
                pin[i][j] = ps[i-1][j];
        end
    end

    // in_reg loads zero on idle cycles so unaccepted inputs never enter the array.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                in_reg[i] <= '0;
                for (int j = 0; j < N; j++) begin
                    w[i][j]  <= '0;
                    ps[i][j] <= '0;
                end
                for (int j = 0; j < N - 1; j++)
                    dr[i][j] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                in_reg[i] <= d_acc ? data_vec[i*DW +: DW] : '0;
                for (int j = 0; j < N; j++) begin
                    if (wt_acc && wr == RW'(i))
                        w[i][j] <= wt_row[j*DW +: DW];
                    ps[i][j] <= pin[i][j] + mul(din[i][j], w[i][j]);
                end
                for (int j = 0; j < N - 1; j++)
                    dr[i][j] <= din[i][j];
            end
        end

    genvar i, j;
    for (i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_d
            assign s_row[i] = in_reg[0];
        end else begin : g_d
            logic [DW-1:0] sr [1:i];
            always_ff @(posedge clk or posedge rst)
                if (rst) begin
                    for (int k = 1; k <= i; k++)
                        sr[k] <= '0;
                end else begin
                    sr[1] <= in_reg[i];
                    for (int k = 2; k <= i; k++)
                        sr[k] <= sr[k-1];
                end
            assign s_row[i] = sr[i];
        end
    end

    // Column j leaves the array j cycles after column 0; delay it N-1-j to realign.
    for (j = 0; j < N; j++) begin : g_deskew
        if (j == N - 1) begin : g_d
            assign col[j] = ps[N-1][j];
        end else begin : g_d
            logic [AW-1:0] sr [1:N-1-j];
            always_ff @(posedge clk or posedge rst)
                if (rst) begin
                    for (int k = 1; k <= N - 1 - j; k++)
                        sr[k] <= '0;
                end else begin
                    sr[1] <= ps[N-1][j];
                    for (int k = 2; k <= N - 1 - j; k++)
                        sr[k] <= sr[k-1];
                end
            assign col[j] = sr[N-1-j];
        end
    end
endmodule
